// File: rtl/axi_write_controller_if.sv
// AXI4 write-channel bundle between the write controller (master) and a slave.
// Burst descriptors are fixed for single-beat traffic, so the interface drives them itself.
interface axi_write_controller_if #(
  parameter int AXI_ADDR_SIZE = 32,
  parameter int AXI_DATA_SIZE = 4
);
  typedef enum logic [2:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2,
    DWORD    = 3'd3
  } axi_burst_size_t;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_t;

  logic [AXI_ADDR_SIZE-1:0]   AWADDR;
  logic [7:0]                 AWLEN;
  axi_burst_size_t            AWSIZE;
  axi_burst_t                 AWBURST;
  logic                       AWVALID;
  logic                       AWREADY;
  logic [8*AXI_DATA_SIZE-1:0] WDATA;
  logic [AXI_DATA_SIZE-1:0]   WSTRB;
  logic                       WLAST;
  logic                       WVALID;
  logic                       WREADY;
  logic                       BVALID;
  logic                       BREADY;

  assign AWLEN   = 8'd0;
  assign AWSIZE  = WORD;
  assign AWBURST = FIXED;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BVALID
  );
endinterface

// File: rtl/axi_write_controller.sv
// Two-requester single-beat AXI write controller: round-robin grant, independent
// AW/W handshakes, then waits for the B response and pulses done_o for the winner.
module axi_write_controller #(
  parameter int AXI_ADDR_SIZE = 32,
  parameter int AXI_DATA_SIZE = 4
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [1:0]                            req_i,
  input  logic [1:0][AXI_ADDR_SIZE-1:0]         addr_i,
  input  logic [1:0][8*AXI_DATA_SIZE-1:0]       data_i,
  input  logic [1:0][AXI_DATA_SIZE-1:0]         strb_i,
  output logic [1:0]                            done_o,
  output logic                                  busy_o,
  axi_write_controller_if.master                axi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       aw_pend_q, aw_pend_d;
  logic                       w_pend_q, w_pend_d;
  logic                       grant_q, grant_d;
  logic                       last_q, last_d;
  logic [1:0]                 done_q, done_d;
  logic [AXI_ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [8*AXI_DATA_SIZE-1:0] data_q, data_d;
  logic [AXI_DATA_SIZE-1:0]   strb_q, strb_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    grant_d   = grant_q;
    last_d    = last_q;
    done_d    = 2'b00;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          // On a tie the requester that was not served most recently wins.
          grant_d   = (req_i == 2'b11) ? ~last_q : req_i[1];
          addr_d    = addr_i[grant_d];
          data_d    = data_i[grant_d];
          strb_d    = strb_i[grant_d];
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (aw_pend_q && axi.AWREADY) aw_pend_d = 1'b0;
        if (w_pend_q && axi.WREADY)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)  state_d   = RESP;
      end
      RESP: begin
        if (axi.BVALID) begin
          done_d[grant_q] = 1'b1;
          last_d          = grant_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the payload registers are reset too because they drive AWADDR/WDATA/WSTRB directly.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q   <= IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      done_q    <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  // Pendings are only ever set on entry to SEND, so they double as the valids.
  assign axi.AWADDR  = addr_q;
  assign axi.WDATA   = data_q;
  assign axi.WSTRB   = strb_q;
  assign axi.AWVALID = aw_pend_q;
  assign axi.WVALID  = w_pend_q;
  assign axi.WLAST   = w_pend_q;
  assign axi.BREADY  = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_axi_write_controller.sv
// Self-checking bench for axi_write_controller: directed scenarios plus a randomized
// run against a transaction-level model of arbitration and channel handshakes.
module tb_axi_write_controller;
  localparam int AW = 32;
  localparam int DB = 4;
  localparam int DW = 8 * DB;

  logic                clk = 1'b0;
  logic                areset;
  logic [1:0]          req;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  data;
  logic [1:0][DB-1:0]  strb;
  logic [1:0]          done;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_last = 1;

  axi_write_controller_if #(.AXI_ADDR_SIZE(AW), .AXI_DATA_SIZE(DB)) axi ();

  axi_write_controller #(.AXI_ADDR_SIZE(AW), .AXI_DATA_SIZE(DB)) dut (
    .ACLK   (clk),
    .ARESET (areset),
    .req_i  (req),
    .addr_i (addr),
    .data_i (data),
    .strb_i (strb),
    .done_o (done),
    .busy_o (busy),
    .axi    (axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: a lone request wins, a tie goes to the one not served last.
  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic slave_idle();
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    areset = 1'b1;
    req = 2'b00;
    addr = '0; data = '0; strb = '0;
    slave_idle();
    repeat (3) tick();
    ctl = {busy, done, axi.AWVALID, axi.WVALID, axi.BREADY};
    n_checks++;
    if (ctl !== 6'b0 || axi.WLAST !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ctl=%b wlast=%b, want 000000/0", ctl, axi.WLAST);
    end
    n_checks++;
    if (axi.AWADDR !== '0 || axi.WDATA !== '0 || axi.WSTRB !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h/%h/%h, want zeros", axi.AWADDR, axi.WDATA, axi.WSTRB);
    end
    n_checks++;
    if (axi.AWLEN !== 8'd0 || 3'(axi.AWSIZE) !== 3'b010 || 2'(axi.AWBURST) !== 2'b00) begin
      n_fail++;
      $display("FAIL burst_consts: got len=%h size=%b burst=%b, want 00/010/00",
               axi.AWLEN, 3'(axi.AWSIZE), 2'(axi.AWBURST));
    end
    areset = 1'b0;
    exp_last = 1;
    tick();
  endtask

  task automatic test_round_robin();
    int got = 0, cyc = 0, eg;
    logic [3:0] order = '0;
    logic [1:0] prev_done = 2'b00;
    addr[0] = 32'hA000_0010; addr[1] = 32'hB000_0020;
    data[0] = 32'h1111_0000; data[1] = 32'h2222_0000;
    strb = {4'h3, 4'hC};
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b1;
    req = 2'b11;
    while (got < 4 && cyc < 60) begin
      tick();
      cyc++;
      eg = pick(2'b11, exp_last);
      if (axi.AWVALID) begin
        n_checks++;
        if (axi.AWADDR !== addr[eg] || axi.WDATA !== data[eg]) begin
          n_fail++;
          $display("FAIL rr_payload: got %h/%h, want %h/%h", axi.AWADDR, axi.WDATA, addr[eg], data[eg]);
        end
      end
      if (done !== 2'b00) begin
        n_checks++;
        if (done !== onehot(eg) || prev_done !== 2'b00) begin
          n_fail++;
          $display("FAIL rr_done: got %b (prev %b), want single pulse %b", done, prev_done, onehot(eg));
        end
        order[got] = eg[0];
        exp_last = eg;
        got++;
        if (got == 4) req = 2'b00;
      end
      prev_done = done;
    end
    n_checks++;
    if (got != 4 || order !== 4'b1010) begin
      n_fail++;
      $display("FAIL rr_order: got %0d txns order(b3..b0)=%b, want 4 txns 1010", got, order);
    end
    tick();
    n_checks++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_quiet: got done=%b busy=%b, want 00/0", done, busy);
    end
    slave_idle();
  endtask

  task automatic test_basic();
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1; axi.BVALID = 1'b1;
    addr[0] = 32'h0000_1000; data[0] = 32'hDEAD_BEEF; strb[0] = 4'hF;
    addr[1] = 32'h5555_5555; data[1] = 32'h6666_6666; strb[1] = 4'h1;
    req = 2'b01;
    tick();
    n_checks++;
    if ({axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy} !== 5'b11101) begin
      n_fail++;
      $display("FAIL basic_valid: got aw/w/last/b/busy=%b, want 11101",
               {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy});
    end
    n_checks++;
    if (axi.AWADDR !== 32'h0000_1000 || axi.WDATA !== 32'hDEAD_BEEF || axi.WSTRB !== 4'hF) begin
      n_fail++;
      $display("FAIL basic_payload: got %h/%h/%h, want 00001000/deadbeef/f", axi.AWADDR, axi.WDATA, axi.WSTRB);
    end
    req = 2'b00;
    addr[0] = 32'hFFFF_0000; data[0] = 32'h0BAD_F00D; strb[0] = 4'h0;
    tick();
    n_checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY, done} !== 5'b00100 ||
        axi.AWADDR !== 32'h0000_1000 || axi.WDATA !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL basic_resp: got aw/w/b/done=%b addr=%h data=%h, want 00100/00001000/deadbeef",
               {axi.AWVALID, axi.WVALID, axi.BREADY, done}, axi.AWADDR, axi.WDATA);
    end
    tick();
    n_checks++;
    if (done !== 2'b01 || busy !== 1'b0 || axi.BREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b busy=%b bready=%b, want 01/0/0", done, busy, axi.BREADY);
    end
    exp_last = 0;
    tick();
    n_checks++;
    if (done !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_pulse: got done=%b, want 00", done);
    end
    slave_idle();
  endtask

  task automatic test_w_before_aw();
    slave_idle();
    axi.WREADY = 1'b1;
    addr[1] = 32'h0000_3000; data[1] = 32'hCAFE_0001; strb[1] = 4'h6;
    req = 2'b10;
    tick();
    n_checks++;
    if ({axi.AWVALID, axi.WVALID} !== 2'b11) begin
      n_fail++;
      $display("FAIL wfirst_start: got aw/w=%b, want 11", {axi.AWVALID, axi.WVALID});
    end
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy} !== 5'b10001) begin
        n_fail++;
        $display("FAIL wfirst_hold%0d: got aw/w/last/b/busy=%b, want 10001", i,
                 {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy});
      end
    end
    axi.AWREADY = 1'b1;
    tick();
    n_checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b001) begin
      n_fail++;
      $display("FAIL wfirst_resp: got aw/w/b=%b, want 001", {axi.AWVALID, axi.WVALID, axi.BREADY});
    end
    axi.BVALID = 1'b1;
    tick();
    n_checks++;
    if (done !== 2'b10) begin
      n_fail++;
      $display("FAIL wfirst_done: got done=%b, want 10", done);
    end
    exp_last = 1;
    slave_idle();
    tick();
  endtask

  task automatic test_bvalid_early();
    slave_idle();
    axi.BVALID = 1'b1;
    addr[0] = 32'h0000_4000; data[0] = 32'h1234_5678; strb[0] = 4'h9;
    req = 2'b01;
    tick();
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({axi.BREADY, done, busy} !== 4'b0001) begin
        n_fail++;
        $display("FAIL bearly_send%0d: got bready/done/busy=%b, want 0001", i, {axi.BREADY, done, busy});
      end
    end
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    tick();
    n_checks++;
    if ({axi.BREADY, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL bearly_resp: got bready/done=%b, want 100", {axi.BREADY, done});
    end
    tick();
    n_checks++;
    if (done !== 2'b01) begin
      n_fail++;
      $display("FAIL bearly_done: got done=%b, want 01", done);
    end
    exp_last = 0;
    slave_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    slave_idle();
    addr[0] = 32'h0000_5000; data[0] = 32'h5A5A_5A5A; strb[0] = 4'hF;
    req = 2'b01;
    tick();
    n_checks++;
    if (axi.AWVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_send: got awvalid=%b, want 1", axi.AWVALID);
    end
    areset = 1'b1;
    req = 2'b00;
    axi.BVALID = 1'b1;
    tick();
    n_checks++;
    if ({axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got aw/w/last/b/busy/done=%b, want 0000000",
               {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy, done});
    end
    areset = 1'b0;
    exp_last = 1;
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    addr[1] = 32'h0000_6000; data[1] = 32'h0F0F_0F0F; strb[1] = 4'h0;
    req = 2'b10;
    tick();
    n_checks++;
    if (axi.AWVALID !== 1'b1 || axi.AWADDR !== 32'h0000_6000 || axi.WSTRB !== 4'h0 || done !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got aw=%b addr=%h strb=%h done=%b, want 1/00006000/0/00",
               axi.AWVALID, axi.AWADDR, axi.WSTRB, done);
    end
    req = 2'b00;
    repeat (2) tick();
    n_checks++;
    if (done !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_done: got done=%b, want 10", done);
    end
    exp_last = 1;
    slave_idle();
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [1:0]    r;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [DB-1:0] es;
      int eg, aw_d, w_d, b_d, aw_wait, w_wait, b_wait, ph, cyc;
      bit hold, aw_done, w_done, exp_awv, exp_wv;
      r = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        addr[k] = $urandom();
        data[k] = $urandom();
        strb[k] = ($urandom_range(0, 3) == 0) ? '0 : DB'($urandom());
      end
      eg = pick(r, exp_last);
      ea = addr[eg]; ed = data[eg]; es = strb[eg];
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      hold = 1'($urandom_range(0, 1));
      slave_idle();
      req = r;
      tick();
      if (!hold) begin
        req = 2'b00;
        addr[0] = $urandom(); addr[1] = $urandom();
        data[0] = $urandom(); data[1] = $urandom();
        strb[0] = DB'($urandom()); strb[1] = DB'($urandom());
      end
      aw_done = 0; w_done = 0; aw_wait = 0; w_wait = 0; b_wait = 0; ph = 1; cyc = 0;
      while (ph != 3 && cyc < 40) begin
        if (ph == 1) begin
          axi.AWREADY = (aw_wait >= aw_d);
          axi.WREADY  = (w_wait >= w_d);
          axi.BVALID  = 1'($urandom_range(0, 1));
        end else begin
          axi.AWREADY = 1'($urandom_range(0, 1));
          axi.WREADY  = 1'($urandom_range(0, 1));
          axi.BVALID  = (b_wait >= b_d);
        end
        exp_awv = (ph == 1) && !aw_done;
        exp_wv  = (ph == 1) && !w_done;
        n_checks++;
        if ({axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy, done} !==
            {exp_awv, exp_wv, exp_wv, (ph == 2), 1'b1, 2'b00}) begin
          n_fail++;
          $display("FAIL rand%0d_ctl: got aw/w/last/b/busy/done=%b, want %b", t,
                   {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, busy, done},
                   {exp_awv, exp_wv, exp_wv, (ph == 2), 1'b1, 2'b00});
        end
        n_checks++;
        if (axi.AWADDR !== ea || axi.WDATA !== ed || axi.WSTRB !== es) begin
          n_fail++;
          $display("FAIL rand%0d_payload: got %h/%h/%h, want %h/%h/%h", t,
                   axi.AWADDR, axi.WDATA, axi.WSTRB, ea, ed, es);
        end
        if (ph == 1) begin
          if (!aw_done) begin
            if (axi.AWREADY) aw_done = 1; else aw_wait++;
          end
          if (!w_done) begin
            if (axi.WREADY) w_done = 1; else w_wait++;
          end
          if (aw_done && w_done) ph = 2;
        end else if (axi.BVALID) begin
          ph = 3;
        end else begin
          b_wait++;
        end
        tick();
        cyc++;
      end
      req = 2'b00;
      n_checks++;
      if (ph != 3 || done !== onehot(eg) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_done: got done=%b busy=%b phase=%0d, want %b/0/3", t, done, busy, ph, onehot(eg));
      end
      exp_last = eg;
      slave_idle();
      tick();
      n_checks++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_after: got done=%b busy=%b, want 00/0", t, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_w_before_aw();
    test_bvalid_early();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_write_controller.md
AXI_WRITE_CONTROLLER -- requirements
Module: axi_write_controller

Interface
REQ-001 Parameter AXI_ADDR_SIZE, default 32, AXI address width in bits.
REQ-002 Parameter AXI_DATA_SIZE, default 4, AXI data width in bytes; WDATA is 8*AXI_DATA_SIZE bits.
REQ-003 ACLK  input  1  single clock; all logic on the rising edge.
REQ-004 ARESET  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  2  per-requester write request, level; held with its payload until the matching done_o pulse.
REQ-006 addr_i  input  2 x AXI_ADDR_SIZE  per-requester write address.
REQ-007 data_i  input  2 x 8*AXI_DATA_SIZE  per-requester write data.
REQ-008 strb_i  input  2 x AXI_DATA_SIZE  per-requester byte strobes.
REQ-009 done_o  output  2  one-cycle completion pulse per requester.
REQ-010 busy_o  output  1  high whenever the FSM is not IDLE.
REQ-011 AWADDR  output  AXI_ADDR_SIZE  latched address of the granted requester.
REQ-012 AWLEN  output  8  constant 0 (single beat).
REQ-013 AWSIZE  output  axi_burst_size_t  constant WORD.
REQ-014 AWBURST  output  axi_burst_t  constant FIXED.
REQ-015 AWVALID  output  1  address valid.
REQ-016 AWREADY  input  1  slave accepts address.
REQ-017 WDATA  output  8*AXI_DATA_SIZE  latched data.
REQ-018 WSTRB  output  AXI_DATA_SIZE  latched strobes.
REQ-019 WLAST  output  1  equals WVALID (every beat is last).
REQ-020 WVALID  output  1  data valid.
REQ-021 WREADY  input  1  slave accepts data.
REQ-022 BVALID  input  1  write response valid.
REQ-023 BREADY  output  1  controller accepts response.

Function
REQ-024 FSM states: IDLE, SEND, RESP.
REQ-025 IDLE: if any req_i bit set, grant one requester, latch its addr/data/strb into AWADDR/WDATA/WSTRB, set aw_pend=w_pend=1, go SEND next cycle.
REQ-026 Arbitration round-robin: single request wins; both requesting -> grant requester not served last; last_served resets to 1 (requester 0 wins first tie).
REQ-027 SEND: AWVALID=aw_pend, WVALID=WLAST=w_pend; AWVALID&AWREADY clears aw_pend, WVALID&WREADY clears w_pend, each independently, in any order or the same cycle.
REQ-028 When both pendings are cleared (including same-cycle handshakes) go RESP next cycle; no valid is reasserted after its handshake.
REQ-029 RESP: BREADY=1; on BVALID pulse done_o[grant] for exactly one cycle, update last_served=grant, return to IDLE.
REQ-030 BREADY is 0 in IDLE and SEND; BVALID outside RESP is ignored.
REQ-031 Latched payload stays stable from IDLE exit until return to IDLE regardless of input changes.
REQ-032 req_i dropped mid-transaction: transaction completes and done_o still pulses.
REQ-033 Minimum latency: grant in cycle N, AW/W valid in N+1, done_o in N+3 with AWREADY=WREADY=1 and BVALID asserted in N+2.
REQ-034 A request held after its done_o is treated as new in the IDLE cycle following done_o (one IDLE cycle between transactions).
REQ-035 All-zero strobes are issued unchanged.

Reset
REQ-036 On ARESET: state IDLE, AWVALID=WVALID=WLAST=BREADY=0, done_o=0, busy_o=0, AWADDR/WDATA/WSTRB=0, last_served=1, pendings=0.
REQ-037 Reset mid-transaction aborts it at the next edge with no done_o pulse; reset dominates every other event.

Verification
REQ-038 Req0 only, addr 0x1000, data 0xDEADBEEF, strb 0xF, slave always ready -> AWADDR=0x1000, WDATA=0xDEADBEEF, WLAST=1, done_o=01 at N+3.
REQ-039 Both requesting continuously, 4 transactions -> grant order 0,1,0,1; each done_o a single-cycle pulse.
REQ-040 WREADY 3 cycles before AWREADY -> WVALID drops after W handshake, AWVALID holds until accepted, then RESP.
REQ-041 BVALID held high during SEND -> BREADY stays 0, no done_o until RESP.
REQ-042 ARESET during SEND with AWVALID=1 -> next cycle all valids 0, busy_o=0, no done_o; req1 afterwards granted normally.
REQ-043 req_i[0] dropped the cycle after grant -> transaction completes with the originally latched payload and done_o[0]=1.
